// File: rtl/data_demod.sv
// Symbol-to-byte reassembler: collects SYM_W-bit symbols LSB-first into DATA_W-bit
// bytes and presents them on a valid/ready output with a one-entry output register.
module data_demod #(
    parameter int SYM_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SYM_W-1:0]          dmod,
    input  logic                      mod_en,
    output logic                      sym_rdy,
    input  logic                      flush,
    output logic [DATA_W-1:0]         data_out,
    output logic                      data_vld,
    input  logic                      data_rdy,
    output logic                      sym_drop,
    output logic [$clog2(DATA_W)-1:0] bit_cnt
);

    localparam int ACC_W = DATA_W + SYM_W - 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int N_W   = $clog2(DATA_W + SYM_W);

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_vld;
    logic              r_drop;

    logic [N_W-1:0]    w_n;
    logic              w_fits;
    logic              w_rdy;
    logic              w_accept;
    logic              w_complete;
    logic [ACC_W-1:0]  w_merged;
    logic [ACC_W-1:0]  w_residue;
    logic [CNT_W-1:0]  w_cnt_wrap;

    // Bits of r_acc at or above r_cnt are always zero, so the new symbol can be OR-ed in.
    assign w_n        = N_W'(r_cnt) + N_W'(SYM_W);
    assign w_fits     = (w_n < N_W'(DATA_W));
    assign w_rdy      = w_fits | ~r_vld | data_rdy;
    assign w_accept   = mod_en & w_rdy & ~flush;
    assign w_complete = w_accept & ~w_fits;
    assign w_merged   = r_acc | (ACC_W'(dmod) << r_cnt);
    assign w_residue  = w_merged >> DATA_W;
    assign w_cnt_wrap = CNT_W'(w_n - N_W'(DATA_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_vld  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            // A flushed cycle ignores the offered symbol, so it cannot count as a drop.
            r_drop <= mod_en & ~w_rdy & ~flush;

            if (flush) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_fits) begin
                    r_acc <= w_merged;
                    r_cnt <= CNT_W'(w_n);
                end else begin
                    r_acc <= w_residue;
                    r_cnt <= w_cnt_wrap;
                end
            end

            if (w_complete) begin
                r_data <= w_merged[DATA_W-1:0];
                r_vld  <= 1'b1;
            end else if (r_vld && data_rdy) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign sym_rdy  = w_rdy;
    assign data_out = r_data;
    assign data_vld = r_vld;
    assign sym_drop = r_drop;
    assign bit_cnt  = r_cnt;

endmodule

// File: tb/tb_data_demod.sv
// Bench for data_demod: table-driven vectors plus a bit-queue scoreboard
// that predicts sym_rdy, sym_drop, bit_cnt and every delivered byte.
module tb_data_demod;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] dmod;
    logic       mod_en;
    logic       sym_rdy;
    logic       flush;
    logic [7:0] data_out;
    logic       data_vld;
    logic       data_rdy;
    logic       sym_drop;
    logic [2:0] bit_cnt;

    data_demod #(.SYM_W(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .dmod(dmod), .mod_en(mod_en), .sym_rdy(sym_rdy),
        .flush(flush), .data_out(data_out), .data_vld(data_vld), .data_rdy(data_rdy),
        .sym_drop(sym_drop), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rs;
        bit [4:0] sym;
        bit       en;
        bit       rdy;
        bit       fl;
        int       srdy;
        int       cnt;
        int       vld;
        int       dout;
        int       drop;
    } vec_t;

    vec_t       tbl[$];
    bit         bitq[$];
    logic [7:0] expq[$];
    bit         exp_drop;
    bit         chk_on;
    int         delivered;
    int         errors;
    int         checks;
    logic [4:0] strm[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rs, input bit [4:0] s, input bit en, input bit rdy, input bit fl,
                       input int srdy, input int cnt, input int vld, input int dout, input int drop);
        vec_t v;
        v.rs = rs; v.sym = s; v.en = en; v.rdy = rdy; v.fl = fl;
        v.srdy = srdy; v.cnt = cnt; v.vld = vld; v.dout = dout; v.drop = drop;
        tbl.push_back(v);
    endtask

    // Drive one cycle at posedge+1, sample mid-cycle against the model, return at next posedge+1.
    task automatic step(input bit rs, input logic [4:0] s, input bit en, input bit rdy, input bit fl,
                        output bit srdy_seen);
        bit         pr;
        logic [7:0] b;
        reset = rs; dmod = s; mod_en = en; data_rdy = rdy; flush = fl;
        #3;
        srdy_seen = sym_rdy;
        if (chk_on) begin
            pr = (bitq.size() + 5 < 8) || (expq.size() == 0) || rdy;
            chk("sym_rdy", int'(sym_rdy), int'(pr));
            chk("data_vld", int'(data_vld), int'(expq.size() != 0));
            chk("bit_cnt", int'(bit_cnt), bitq.size());
            chk("sym_drop", int'(sym_drop), int'(exp_drop));
            if (data_vld && rdy && expq.size() != 0) begin
                chk("byte", int'(data_out), int'(expq.pop_front()));
                delivered++;
            end
            if (rs) begin
                bitq.delete();
                expq.delete();
                exp_drop = 1'b0;
            end else begin
                exp_drop = en && !pr && !fl;
                if (fl) begin
                    bitq.delete();
                end else if (en && pr) begin
                    for (int i = 0; i < 5; i++) bitq.push_back(s[i]);
                    if (bitq.size() >= 8) begin
                        for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
                        expq.push_back(b);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit sr;
        int lows;
        int d0;
        errors = 0; checks = 0; delivered = 0; exp_drop = 1'b0; chk_on = 1'b0;
        strm[0] = 5'h01; strm[1] = 5'h18; strm[2] = 5'h08; strm[3] = 5'h0A;
        strm[4] = 5'h14; strm[5] = 5'h13; strm[6] = 5'h05; strm[7] = 5'h11;

        // Plain stream, always ready
        add(0, 5'h01, 1, 1, 0, 1, 5, 0, 'h00, 0);
        add(0, 5'h18, 1, 1, 0, 1, 2, 1, 'h01, 0);
        add(0, 5'h08, 1, 1, 0, 1, 7, 0, 'h01, 0);
        add(0, 5'h0A, 1, 1, 0, 1, 4, 1, 'h23, 0);
        add(0, 5'h14, 1, 1, 0, 1, 1, 1, 'h45, 0);
        add(0, 5'h13, 1, 1, 0, 1, 6, 0, 'h45, 0);
        add(0, 5'h05, 1, 1, 0, 1, 3, 1, 'h67, 0);
        add(0, 5'h11, 1, 1, 0, 1, 0, 1, 'h89, 0);
        add(0, 5'h00, 0, 1, 0, 1, 0, 0, 'h89, 0);
        // Backpressure: completing symbol refused and dropped, then retried
        add(1, 5'h00, 0, 1, 0, 1, 0, 0, 'h00, 0);
        add(0, 5'h01, 1, 0, 0, 1, 5, 0, 'h00, 0);
        add(0, 5'h18, 1, 0, 0, 1, 2, 1, 'h01, 0);
        add(0, 5'h08, 1, 0, 0, 1, 7, 1, 'h01, 0);
        add(0, 5'h0A, 1, 0, 0, 0, 7, 1, 'h01, 1);
        add(0, 5'h0A, 1, 0, 0, 0, 7, 1, 'h01, 1);
        add(0, 5'h0A, 1, 1, 0, 1, 4, 1, 'h23, 0);
        add(0, 5'h14, 1, 1, 0, 1, 1, 1, 'h45, 0);
        add(0, 5'h13, 1, 1, 0, 1, 6, 0, 'h45, 0);
        add(0, 5'h05, 1, 1, 0, 1, 3, 1, 'h67, 0);
        add(0, 5'h11, 1, 1, 0, 1, 0, 1, 'h89, 0);
        add(0, 5'h00, 0, 1, 0, 1, 0, 0, 'h89, 0);
        // Flush with symbol offered (accepted and refused cases), pending byte survives
        add(1, 5'h00, 0, 1, 0, 1, 0, 0, 'h00, 0);
        add(0, 5'h01, 1, 0, 0, 1, 5, 0, 'h00, 0);
        add(0, 5'h18, 1, 0, 0, 1, 2, 1, 'h01, 0);
        add(0, 5'h08, 1, 0, 1, 1, 0, 1, 'h01, 0);
        add(0, 5'h01, 1, 0, 0, 1, 5, 1, 'h01, 0);
        add(0, 5'h18, 1, 0, 1, 0, 0, 1, 'h01, 0);
        add(0, 5'h00, 0, 1, 0, 1, 0, 0, 'h01, 0);
        add(0, 5'h01, 1, 1, 0, 1, 5, 0, 'h01, 0);
        add(0, 5'h18, 1, 1, 0, 1, 2, 1, 'h01, 0);
        add(0, 5'h08, 1, 1, 0, 1, 7, 0, 'h01, 0);
        add(0, 5'h0A, 1, 1, 0, 1, 4, 1, 'h23, 0);
        add(0, 5'h14, 1, 1, 0, 1, 1, 1, 'h45, 0);
        add(0, 5'h13, 1, 1, 0, 1, 6, 0, 'h45, 0);
        add(0, 5'h05, 1, 1, 0, 1, 3, 1, 'h67, 0);
        add(0, 5'h11, 1, 1, 0, 1, 0, 1, 'h89, 0);
        add(0, 5'h00, 0, 1, 0, 1, 0, 0, 'h89, 0);

        reset = 1'b1; dmod = '0; mod_en = 1'b0; flush = 1'b0; data_rdy = 1'b0;
        @(posedge clk); #1;
        step(1, 5'h00, 0, 0, 0, sr);
        step(1, 5'h00, 0, 0, 0, sr);
        chk_on = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].rs, tbl[k].sym, tbl[k].en, tbl[k].rdy, tbl[k].fl, sr);
            chk("tbl_srdy", int'(sr), tbl[k].srdy);
            chk("tbl_cnt", int'(bit_cnt), tbl[k].cnt);
            chk("tbl_vld", int'(data_vld), tbl[k].vld);
            chk("tbl_dout", int'(data_out), tbl[k].dout);
            chk("tbl_drop", int'(sym_drop), tbl[k].drop);
        end

        // Three back-to-back streams: 15 bytes, no stall
        lows = 0;
        d0 = delivered;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(0, strm[i], 1, 1, 0, sr);
                if (!sr) lows++;
            end
        end
        step(0, 5'h00, 0, 1, 0, sr);
        chk("rep_srdy_low", lows, 0);
        chk("rep_bytes", delivered - d0, 15);
        chk("rep_cnt", int'(bit_cnt), 0);

        // Reset with residual bits and a pending byte
        for (int i = 0; i < 4; i++) step(0, strm[i], 1, 1, 0, sr);
        chk("pre_rst_cnt", int'(bit_cnt), 4);
        chk("pre_rst_vld", int'(data_vld), 1);
        step(1, 5'h00, 0, 0, 0, sr);
        chk("rst_vld", int'(data_vld), 0);
        chk("rst_cnt", int'(bit_cnt), 0);
        chk("rst_srdy", int'(sym_rdy), 1);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_drop", int'(sym_drop), 0);

        // Random traffic against the bit-queue model
        for (int i = 0; i < 1500; i++) begin
            step(0, 5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0, sr);
        end
        step(0, 5'h00, 0, 1, 0, sr);
        step(0, 5'h00, 0, 1, 0, sr);
        chk("rand_leftover", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
